// File: rtl/gemm_pkg.sv
// Shared types for the GEMM command path: operation codes, the decoded command
// record held in the queue, and the sequencer state encoding.
package gemm_pkg;

  typedef enum logic [1:0] {
    LOAD_W  = 2'd0,
    LOAD_A  = 2'd1,
    COMPUTE = 2'd2,
    STORE   = 2'd3
  } gemm_op_e;

  localparam logic [6:0] GEMM_OPCODE = 7'b0001011;

  typedef struct packed {
    gemm_op_e    op;
    logic        legal;
    logic [31:0] addr;
    logic [15:0] len;
  } gemm_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ABORT,
    S_DONE
  } gemm_state_e;

  // Only funct3 values 0..3 map onto an accelerator operation.
  function automatic gemm_cmd_t gemm_decode(input logic [6:0]  opcode,
                                            input logic [2:0]  funct3,
                                            input logic [31:0] base,
                                            input logic [15:0] len);
    gemm_cmd_t cmd;
    cmd.op    = gemm_op_e'(funct3[1:0]);
    cmd.legal = (opcode == GEMM_OPCODE) && (funct3 <= 3'd3);
    cmd.addr  = base;
    cmd.len   = len;
    return cmd;
  endfunction

endpackage

// File: rtl/gemm_cmd_ctrl_if.sv
// Core-side GEMM issue port: command in, completion status and back-pressure out.
interface gemm_cmd_ctrl_if;

  logic        gemm_valid;
  logic [31:0] gemm_instruction;
  logic [31:0] gemm_rdata1;
  logic [31:0] gemm_rdata2;
  logic        gemm_done;
  logic        gemm_err;
  logic        gemm_full;

  modport master (
    output gemm_valid, gemm_instruction, gemm_rdata1, gemm_rdata2,
    input  gemm_done, gemm_err, gemm_full
  );

  modport slave (
    input  gemm_valid, gemm_instruction, gemm_rdata1, gemm_rdata2,
    output gemm_done, gemm_err, gemm_full
  );

endinterface

// File: rtl/gemm_cmd_fifo.sv
// Synchronous FIFO of decoded GEMM commands; head is the oldest entry,
// full/empty come from the registered occupancy.
module gemm_cmd_fifo
  import gemm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  gemm_cmd_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output gemm_cmd_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  gemm_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gemm_cmd_ctrl.sv
// GEMM command sequencer: queues decoded core commands and dispatches them one
// at a time to the accelerator with a start/done handshake and a watchdog.
module gemm_cmd_ctrl
  import gemm_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  gemm_cmd_ctrl_if.slave     core,
  output logic               acc_start,
  output logic [1:0]         acc_op,
  output logic [31:0]        acc_addr,
  output logic [15:0]        acc_len,
  input  logic               acc_done,
  output logic               acc_abort,
  output logic               ovf,
  output logic [31:0]        cmd_count
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  gemm_state_e     state;
  logic [WD_W-1:0] wd;
  gemm_cmd_t       push_cmd;
  gemm_cmd_t       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;

  assign push_cmd = gemm_decode(core.gemm_instruction[6:0], core.gemm_instruction[14:12],
                                core.gemm_rdata1, core.gemm_rdata2[15:0]);
  assign pop = (state == S_DONE);
  assign core.gemm_full = fifo_full;

  gemm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (core.gemm_valid),
    .din   (push_cmd),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // A push against a full queue is dropped inside the FIFO; remember that it happened.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf <= 1'b0;
    else if (core.gemm_valid && fifo_full) ovf <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      wd             <= '0;
      acc_start      <= 1'b0;
      acc_abort      <= 1'b0;
      acc_op         <= '0;
      acc_addr       <= '0;
      acc_len        <= '0;
      core.gemm_done <= 1'b0;
      core.gemm_err  <= 1'b0;
      cmd_count      <= '0;
    end else begin
      acc_start      <= 1'b0;
      acc_abort      <= 1'b0;
      core.gemm_done <= 1'b0;
      core.gemm_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (!head.legal) begin
              state          <= S_DONE;
              core.gemm_done <= 1'b1;
              core.gemm_err  <= 1'b1;
            end else if (head.len == '0) begin
              state          <= S_DONE;
              core.gemm_done <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              acc_start <= 1'b1;
              acc_op    <= head.op;
              acc_addr  <= head.addr;
              acc_len   <= head.len;
            end
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        // Completion takes priority over the watchdog expiring in the same cycle.
        S_WAIT: begin
          wd <= wd + 1'b1;
          if (acc_done) begin
            state          <= S_DONE;
            core.gemm_done <= 1'b1;
          end else if (wd == WD_LAST) begin
            state     <= S_ABORT;
            acc_abort <= 1'b1;
          end
        end
        S_ABORT: begin
          state          <= S_DONE;
          core.gemm_done <= 1'b1;
          core.gemm_err  <= 1'b1;
        end
        S_DONE: begin
          if (!core.gemm_err) cmd_count <= cmd_count + 32'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_cmd_ctrl.sv
// Scoreboard bench for gemm_cmd_ctrl: directed scenarios plus flow-controlled
// random commands, checked against a command-level reference model.
module tb_gemm_cmd_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_start;
  logic [1:0]  acc_op;
  logic [31:0] acc_addr;
  logic [15:0] acc_len;
  logic        acc_done;
  logic        acc_abort;
  logic        ovf;
  logic [31:0] cmd_count;

  gemm_cmd_ctrl_if core_if ();

  gemm_cmd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .core      (core_if.slave),
    .acc_start (acc_start),
    .acc_op    (acc_op),
    .acc_addr  (acc_addr),
    .acc_len   (acc_len),
    .acc_done  (acc_done),
    .acc_abort (acc_abort),
    .ovf       (ovf),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int err;
    int cyc;
  } done_exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [15:0] len;
    int          cyc;
  } start_exp_t;

  done_exp_t   done_q[$];
  start_exp_t  start_q[$];
  int          abort_q[$];
  int          lat_q[$];
  logic [31:0] exp_cnt = '0;
  bit          cnt_pending = 1'b0;
  int          dones_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expectations come from the command rules and the documented
  // latencies (timed entries assume the sequencer is idle at push time).
  task automatic drive_cmd(input logic [31:0] instr, input logic [31:0] r1,
                           input logic [31:0] r2, input int lat, input bit timed);
    int         c;
    bit         legal;
    logic [15:0] len;
    c = cyc;
    core_if.gemm_valid       = 1'b1;
    core_if.gemm_instruction = instr;
    core_if.gemm_rdata1      = r1;
    core_if.gemm_rdata2      = r2;
    legal = (instr[6:0] == 7'b0001011) && (instr[14:12] <= 3'd3);
    len   = r2[15:0];
    if (!legal) begin
      done_q.push_back('{1, timed ? c + 2 : -1});
    end else if (len == 16'd0) begin
      done_q.push_back('{0, timed ? c + 2 : -1});
    end else begin
      start_q.push_back('{instr[13:12], r1, len, timed ? c + 2 : -1});
      lat_q.push_back(lat);
      if (lat >= 1 && lat <= int'(TIMEOUT)) begin
        done_q.push_back('{0, timed ? c + 3 + lat : -1});
      end else begin
        abort_q.push_back(timed ? c + 3 + int'(TIMEOUT) : -1);
        done_q.push_back('{1, timed ? c + 4 + int'(TIMEOUT) : -1});
      end
    end
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] r1,
                          input logic [31:0] r2, input int lat);
    @(posedge clk); #1;
    drive_cmd(instr, r1, r2, lat, 1'b1);
    @(posedge clk); #1;
    core_if.gemm_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((done_q.size() != 0 || cnt_pending) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) check("drain_timeout", done_q.size() + int'(cnt_pending), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc_start"}, acc_start, 0);
    check({tag, "_acc_abort"}, acc_abort, 0);
    check({tag, "_acc_op"}, acc_op, 0);
    check({tag, "_acc_addr"}, acc_addr, 0);
    check({tag, "_acc_len"}, acc_len, 0);
    check({tag, "_gemm_done"}, core_if.gemm_done, 0);
    check({tag, "_gemm_err"}, core_if.gemm_err, 0);
    check({tag, "_gemm_full"}, core_if.gemm_full, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_cmd_count"}, cmd_count, 0);
  endtask

  // Accelerator responder: latency 0 means it never answers.
  initial begin
    acc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && acc_start === 1'b1) begin
        int lat;
        lat = (lat_q.size() == 0) ? 0 : lat_q.pop_front();
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1 acc_done = 1'b1;
          @(posedge clk);
          #1 acc_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (cnt_pending) begin
          check("cmd_count", cmd_count, exp_cnt);
          cnt_pending = 1'b0;
        end
        if (acc_start) begin
          if (start_q.size() == 0) begin
            check("unexpected_acc_start", acc_start, 0);
          end else begin
            start_exp_t e;
            e = start_q.pop_front();
            check("acc_op", acc_op, e.op);
            check("acc_addr", acc_addr, e.addr);
            check("acc_len", acc_len, e.len);
            if (e.cyc >= 0) check("acc_start_cycle", cyc, e.cyc);
          end
        end
        if (acc_abort) begin
          if (abort_q.size() == 0) begin
            check("unexpected_acc_abort", acc_abort, 0);
          end else begin
            int ac;
            ac = abort_q.pop_front();
            if (ac >= 0) check("acc_abort_cycle", cyc, ac);
          end
        end
        if (core_if.gemm_done) begin
          dones_seen++;
          if (done_q.size() == 0) begin
            check("unexpected_gemm_done", core_if.gemm_done, 0);
          end else begin
            done_exp_t d;
            d = done_q.pop_front();
            check("gemm_err", core_if.gemm_err, d.err);
            if (d.cyc >= 0) check("gemm_done_cycle", cyc, d.cyc);
            if (d.err == 0) exp_cnt = exp_cnt + 32'd1;
            cnt_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] instr, r1, r2, ins;
    int          lat, gap, guard, seen;

    core_if.gemm_valid       = 1'b0;
    core_if.gemm_instruction = '0;
    core_if.gemm_rdata1      = '0;
    core_if.gemm_rdata2      = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;

    push_one(32'h0000200B, 32'h0000_1000, 32'h0000_0010, 5);
    wait_drain(200);
    push_one(32'h00000033, 32'h0000_ABCD, 32'h0000_0020, 0);
    wait_drain(200);
    push_one(32'h0000100B, 32'h0000_2000, 32'hFFFF_0000, 0);
    wait_drain(200);
    push_one(32'h0000300B, 32'h0000_3000, 32'h0000_0004, 0);
    wait_drain(200);
    push_one(32'h0000000B, 32'h0000_4000, 32'h0000_0008, int'(TIMEOUT));
    wait_drain(200);
    check("cmd_count_directed", cmd_count, 3);

    for (int i = 0; i < 40; i++) begin
      gap   = $urandom_range(0, 2);
      guard = 0;
      @(posedge clk); #1 core_if.gemm_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      while (core_if.gemm_full && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      instr = $urandom;
      if ($urandom_range(0, 9) < 8) instr[6:0] = 7'b0001011;
      r1 = $urandom;
      r2 = $urandom;
      if ($urandom_range(0, 4) == 0) r2[15:0] = 16'h0000;
      lat = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      drive_cmd(instr, r1, r2, lat, 1'b0);
    end
    @(posedge clk); #1 core_if.gemm_valid = 1'b0;
    wait_drain(3000);
    check("ovf_after_random", ovf, 0);

    // Five consecutive pushes against a slow accelerator: the fifth hits a full queue.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i < 4) begin
        ins = 32'h0000000B | (32'(i) << 12);
        drive_cmd(ins, 32'h0000_5000 + 32'(i * 16), 32'h0000_0020 + 32'(i), 6, 1'b0);
      end else begin
        core_if.gemm_valid       = 1'b1;
        core_if.gemm_instruction = 32'h0000200B;
        core_if.gemm_rdata1      = 32'h0000_6000;
        core_if.gemm_rdata2      = 32'h0000_0040;
      end
      #2 check($sformatf("gemm_full_at_push%0d", i), core_if.gemm_full, (i == 4));
    end
    @(posedge clk); #1 core_if.gemm_valid = 1'b0;
    #2 check("ovf_sticky", ovf, 1);
    wait_drain(500);
    check("ovf_still_set", ovf, 1);

    // Three commands queued, the first stuck in WAIT, then an asynchronous reset.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      drive_cmd(32'h0000100B, 32'h0000_7000 + 32'(i), 32'h0000_0010, 0, 1'b0);
    end
    @(posedge clk); #1 core_if.gemm_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1 check_all_zero("reset_mid_wait");
    done_q.delete();
    start_q.delete();
    abort_q.delete();
    lat_q.delete();
    exp_cnt     = '0;
    cnt_pending = 1'b0;
    seen        = dones_seen;
    @(posedge clk); #1 rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_reset", dones_seen, seen);
    check("full_after_reset", core_if.gemm_full, 0);
    check("cmd_count_after_reset", cmd_count, 0);

    push_one(32'h0000300B, 32'h0000_8000, 32'h0000_0003, 2);
    wait_drain(200);
    check("cmd_count_post_reset_cmd", cmd_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
